// File: rtl/fetch_pkg.sv
// Shared encodings and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int              INSTR_W      = 16;
    localparam logic [15:0]     DEF_RESET_PC = 16'h0000;
    localparam int              DEF_PC_STEP  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FAULT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_LOAD = 2'd1,
        PC_INC  = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with load/increment/hold select and the pc+step adder.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int                PC_STEP  = DEF_PC_STEP
) (
    input  logic              clock,
    input  logic              reset,
    input  pc_sel_e           sel,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus
);

    // Modulo 2^ADDR_W: the top address wraps to zero.
    assign pc_plus = pc + ADDR_W'(PC_STEP);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            case (sel)
                PC_LOAD: pc <= load_val;
                PC_INC:  pc <= pc_plus;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, req/ack memory handshake, IR write strobe.
// Optional ack-wait timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(DEF_RESET_PC),
    parameter int                PC_STEP        = DEF_PC_STEP,
    parameter int                TIMEOUT_CYCLES = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetch_go,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir_data,
    output logic               ir_write,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus,
    output logic               busy,
    output logic               fetch_fault
);

    state_e             state, state_n;
    logic               mem_req_n;
    logic [ADDR_W-1:0]  mem_addr_n;
    logic [INSTR_W-1:0] ir_data_n;
    logic               ir_write_n;
    logic               redirect_pend, redirect_pend_n;
    logic [ADDR_W-1:0]  redirect_tgt, redirect_tgt_n;
    pc_sel_e            pc_sel;
    logic [ADDR_W-1:0]  pc_ld_val;
    logic               timeout;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clock    (clock),
        .reset    (reset),
        .sel      (pc_sel),
        .load_val (pc_ld_val),
        .pc       (pc_out),
        .pc_plus  (pc_plus)
    );

    assign busy = (state == REQ);

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 16) ? 4 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Zero whenever not in REQ, so the first REQ cycle always counts from 0.
    always_ff @(posedge clock) begin
        if (reset || state != REQ) wait_cnt <= '0;
        else                       wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout     = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign fetch_fault = (state == FAULT);
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYCLES != 0);
    assign timeout     = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            ir_data       <= '0;
            ir_write      <= 1'b0;
            redirect_pend <= 1'b0;
            redirect_tgt  <= '0;
        end else begin
            state         <= state_n;
            mem_req       <= mem_req_n;
            mem_addr      <= mem_addr_n;
            ir_data       <= ir_data_n;
            ir_write      <= ir_write_n;
            redirect_pend <= redirect_pend_n;
            redirect_tgt  <= redirect_tgt_n;
        end
    end

    always_comb begin
        state_n         = state;
        mem_req_n       = mem_req;
        mem_addr_n      = mem_addr;
        ir_data_n       = ir_data;
        ir_write_n      = 1'b0;
        redirect_pend_n = redirect_pend;
        redirect_tgt_n  = redirect_tgt;
        pc_sel          = PC_HOLD;
        pc_ld_val       = pc_in;
        case (state)
            IDLE: begin
                if (fetch_go) begin
                    // A redirect in the same cycle wins over the current PC.
                    pc_ld_val       = pc_load ? pc_in : pc_out;
                    pc_sel          = PC_LOAD;
                    mem_addr_n      = pc_ld_val;
                    mem_req_n       = 1'b1;
                    redirect_pend_n = 1'b0;
                    state_n         = REQ;
                end else if (pc_load) begin
                    pc_sel = PC_LOAD;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_n         = IDLE;
                    mem_req_n       = 1'b0;
                    redirect_pend_n = 1'b0;
                    if (pc_load || redirect_pend) begin
                        // Word belongs to the abandoned path: drop it.
                        pc_sel    = PC_LOAD;
                        pc_ld_val = pc_load ? pc_in : redirect_tgt;
                    end else begin
                        ir_data_n  = mem_rdata;
                        ir_write_n = 1'b1;
                        pc_sel     = PC_INC;
                    end
                end else begin
                    if (pc_load) begin
                        redirect_pend_n = 1'b1;
                        redirect_tgt_n  = pc_in;
                    end
                    if (timeout) begin
                        state_n   = FAULT;
                        mem_req_n = 1'b0;
                    end
                end
            end
            FAULT: mem_req_n = 1'b0;
            default: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; timeout section active with FETCH_TIMEOUT_EN.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_go;
    logic        pc_load;
    logic [15:0] pc_in;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir_data;
    logic        ir_write;
    logic [15:0] pc_out;
    logic [15:0] pc_plus;
    logic        busy;
    logic        fetch_fault;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_go    (fetch_go),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir_data     (ir_data),
        .ir_write    (ir_write),
        .pc_out      (pc_out),
        .pc_plus     (pc_plus),
        .busy        (busy),
        .fetch_fault (fetch_fault)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete fetch from IDLE; fetch_go is held high during wait states.
    task automatic do_fetch(input logic [15:0] addr, input logic [15:0] word, input int waits);
        logic [15:0] nxt;
        nxt = addr + 16'd2;
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        chk1 ("req_set", mem_req, 1'b1);
        chk16("req_addr", mem_addr, addr);
        chk1 ("busy_set", busy, 1'b1);
        for (int i = 0; i < waits; i++) begin
            fetch_go = 1'b1;
            tick();
            chk1 ("wait_req", mem_req, 1'b1);
            chk16("wait_addr", mem_addr, addr);
            chk1 ("wait_nowr", ir_write, 1'b0);
            chk1 ("wait_busy", busy, 1'b1);
        end
        fetch_go  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = word;
        tick();
        mem_ack = 1'b0;
        chk1 ("strobe", ir_write, 1'b1);
        chk16("ir_data", ir_data, word);
        chk16("pc_inc", pc_out, nxt);
        chk1 ("req_drop", mem_req, 1'b0);
        chk1 ("busy_drop", busy, 1'b0);
        tick();
        chk1 ("strobe_1cyc", ir_write, 1'b0);
        chk16("ir_hold", ir_data, word);
        chk1 ("go_not_queued", mem_req, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        fetch_go  = 1'b0;
        pc_load   = 1'b0;
        pc_in     = 16'h0000;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        tick();
        tick();
        chk1 ("rst_req", mem_req, 1'b0);
        chk16("rst_addr", mem_addr, 16'h0000);
        chk1 ("rst_wr", ir_write, 1'b0);
        chk16("rst_ir", ir_data, 16'h0000);
        chk16("rst_pc", pc_out, 16'h0000);
        chk16("rst_pcplus", pc_plus, 16'h0002);
        chk1 ("rst_busy", busy, 1'b0);
        chk1 ("rst_fault", fetch_fault, 1'b0);

        // Stale ack in IDLE is ignored.
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        chk1 ("stale_wr", ir_write, 1'b0);
        chk16("stale_ir", ir_data, 16'h0000);
        chk1 ("stale_req", mem_req, 1'b0);

        // Sequential fetches.
        do_fetch(16'h0000, 16'h1234, 0);
        do_fetch(16'h0002, 16'h5678, 0);
        do_fetch(16'h0004, 16'h9ABC, 0);
        chk16("seq_pc", pc_out, 16'h0006);

        // Wait states with ignored fetch_go pulses.
        do_fetch(16'h0006, 16'hCAFE, 5);
        chk16("wait_pc", pc_out, 16'h0008);

        // Redirect and fetch_go together in IDLE.
        pc_load  = 1'b1;
        pc_in    = 16'h0040;
        fetch_go = 1'b1;
        tick();
        pc_load  = 1'b0;
        fetch_go = 1'b0;
        chk16("redir_addr", mem_addr, 16'h0040);
        chk16("redir_pc", pc_out, 16'h0040);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1111;
        tick();
        mem_ack = 1'b0;
        chk1 ("redir_wr", ir_write, 1'b1);
        chk16("redir_ir", ir_data, 16'h1111);
        chk16("redir_pc2", pc_out, 16'h0042);

        // Redirect during REQ, two cycles before ack.
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        chk16("rq_addr", mem_addr, 16'h0042);
        tick();
        pc_load = 1'b1;
        pc_in   = 16'h0100;
        tick();
        pc_load = 1'b0;
        pc_in   = 16'h0000;
        tick();
        chk16("rq_addr_hold", mem_addr, 16'h0042);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        chk1 ("rq_nowr", ir_write, 1'b0);
        chk16("rq_ir_keep", ir_data, 16'h1111);
        chk16("rq_pc", pc_out, 16'h0100);
        chk1 ("rq_req", mem_req, 1'b0);
        do_fetch(16'h0100, 16'h2222, 0);

        // pc_load in the very cycle of the ack.
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        chk16("ackld_addr", mem_addr, 16'h0102);
        pc_load   = 1'b1;
        pc_in     = 16'h0200;
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        tick();
        pc_load = 1'b0;
        mem_ack = 1'b0;
        chk1 ("ackld_nowr", ir_write, 1'b0);
        chk16("ackld_ir", ir_data, 16'h2222);
        chk16("ackld_pc", pc_out, 16'h0200);

        // Odd address passes through unchanged.
        pc_load = 1'b1;
        pc_in   = 16'h0011;
        tick();
        pc_load = 1'b0;
        chk16("odd_pc", pc_out, 16'h0011);
        chk1 ("odd_noreq", mem_req, 1'b0);
        do_fetch(16'h0011, 16'hA5A5, 0);

        // Wrap at the top of the address space.
        pc_load = 1'b1;
        pc_in   = 16'hFFFE;
        tick();
        pc_load = 1'b0;
        chk16("wrap_plus", pc_plus, 16'h0000);
        do_fetch(16'hFFFE, 16'h3333, 0);
        chk16("wrap_pc", pc_out, 16'h0000);

        // Reset mid-REQ with a pending redirect, then a late ack.
        pc_load = 1'b1;
        pc_in   = 16'h0010;
        tick();
        pc_load  = 1'b0;
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        chk16("ab_addr", mem_addr, 16'h0010);
        pc_load = 1'b1;
        pc_in   = 16'h0300;
        tick();
        pc_load = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        chk1 ("ab_req", mem_req, 1'b0);
        chk1 ("ab_busy", busy, 1'b0);
        chk16("ab_pc", pc_out, 16'h0000);
        mem_ack   = 1'b1;
        mem_rdata = 16'h4444;
        tick();
        mem_ack = 1'b0;
        chk1 ("ab_nowr", ir_write, 1'b0);
        chk16("ab_ir", ir_data, 16'h0000);
        chk16("ab_pc2", pc_out, 16'h0000);
        do_fetch(16'h0000, 16'h5555, 0);

`ifdef FETCH_TIMEOUT_EN
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk1("to_wait_req", mem_req, 1'b1);
            chk1("to_wait_fault", fetch_fault, 1'b0);
        end
        tick();
        chk1("to_fault", fetch_fault, 1'b1);
        chk1("to_req", mem_req, 1'b0);
        chk1("to_busy", busy, 1'b0);
        fetch_go = 1'b1;
        pc_load  = 1'b1;
        pc_in    = 16'h0500;
        mem_ack  = 1'b1;
        tick();
        tick();
        fetch_go = 1'b0;
        pc_load  = 1'b0;
        mem_ack  = 1'b0;
        chk1 ("to_sticky", fetch_fault, 1'b1);
        chk1 ("to_stuck_req", mem_req, 1'b0);
        chk1 ("to_stuck_wr", ir_write, 1'b0);
        chk16("to_stuck_pc", pc_out, 16'h0002);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1 ("to_clear", fetch_fault, 1'b0);
        chk16("to_rst_pc", pc_out, 16'h0000);
`else
        // Without the timeout a long wait must not fault.
        do_fetch(16'h0002, 16'h6666, 20);
        chk1("no_fault", fetch_fault, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
